// File: rtl/pattern_gen_if.sv
// Timing-in / pixel-out bundle between frameGenerator, pattern_gen and the DAC pins.
// master drives timing and control and receives pixels; slave is the generator side.
interface pattern_gen_if #(
  parameter int COLOR_BITS = 4,
  parameter int POS_BITS   = 10
);
  logic                  videoActive;
  logic [POS_BITS-1:0]   hPos;
  logic [POS_BITS-1:0]   vPos;
  logic                  hsync_in;
  logic                  vsync_in;
  logic [2:0]            mode;
  logic                  scroll_en;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;
  logic                  hsync;
  logic                  vsync;
  logic [7:0]            frameCount;

  modport master (
    output videoActive, hPos, vPos, hsync_in, vsync_in, mode, scroll_en,
    input  red, green, blue, hsync, vsync, frameCount
  );

  modport slave (
    input  videoActive, hPos, vPos, hsync_in, vsync_in, mode, scroll_en,
    output red, green, blue, hsync, vsync, frameCount
  );
endinterface

// File: rtl/pattern_gen.sv
// Multi-mode video test-pattern generator: registered RGB with 1-cycle delay-matched syncs,
// mode and scroll latched only on the vsync leading edge so a frame never tears.
module pattern_gen #(
  parameter int COLOR_BITS  = 4,
  parameter int POS_BITS    = 10,
  parameter int SQUARE_LOG2 = 4,
  parameter int H_ACTIVE    = 800,
  parameter int SCROLL_STEP = 1,
  parameter int SYNC_POL    = 1
) (
  input  logic          clk40,
  input  logic          reset,
  pattern_gen_if.slave  bus
);

  localparam int   BAR_W       = H_ACTIVE / 8;
  localparam int   BAR_PX_BITS = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic SYNC_ACT    = (SYNC_POL != 0);

  localparam logic [2:0] MODE_CHECKER    = 3'd0;
  localparam logic [2:0] MODE_BARS       = 3'd1;
  localparam logic [2:0] MODE_GRADIENT   = 3'd2;
  localparam logic [2:0] MODE_WHITE      = 3'd3;
  localparam logic [2:0] MODE_CROSSHATCH = 3'd4;

  logic [2:0]             mode_reg;
  logic [POS_BITS-1:0]    scroll_reg;
  logic [7:0]             frame_count_reg;
  logic                   vsync_d_reg;
  logic                   hsync_reg;
  logic [BAR_PX_BITS-1:0] bar_px_reg;
  logic [2:0]             bar_idx_reg;

  logic                   frame_start;
  logic [POS_BITS-1:0]    hx;
  logic [2:0]             mask_next;
  logic                   grad_sel;

  // Channel order in the arrays below: 2 = red, 1 = green, 0 = blue.
  logic [COLOR_BITS-1:0]  grad_val [3];
  logic [COLOR_BITS-1:0]  rgb_next [3];
  logic [COLOR_BITS-1:0]  rgb_reg  [3];

  // Leading edge of vsync, judged against our own registered copy of vsync_in.
  assign frame_start = (vsync_d_reg == ~SYNC_ACT) && (bus.vsync_in == SYNC_ACT);
  assign hx          = bus.hPos + scroll_reg;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    m = 3'b000;
    case (idx)
      3'd0:    m = 3'b111;  // white
      3'd1:    m = 3'b110;  // yellow
      3'd2:    m = 3'b011;  // cyan
      3'd3:    m = 3'b010;  // green
      3'd4:    m = 3'b101;  // magenta
      3'd5:    m = 3'b100;  // red
      3'd6:    m = 3'b001;  // blue
      default: m = 3'b000;  // black
    endcase
    return m;
  endfunction

  always_comb begin
    mask_next = 3'b000;
    grad_sel  = 1'b0;
    case (mode_reg)
      MODE_CHECKER:    mask_next = {hx[SQUARE_LOG2], bus.vPos[SQUARE_LOG2], ~hx[SQUARE_LOG2]};
      MODE_BARS:       mask_next = bar_mask(bar_idx_reg);
      MODE_GRADIENT:   grad_sel  = 1'b1;
      MODE_WHITE:      mask_next = 3'b111;
      MODE_CROSSHATCH: begin
        if ((hx[SQUARE_LOG2-1:0] == '0) || (bus.vPos[SQUARE_LOG2-1:0] == '0))
          mask_next = 3'b111;
      end
      default:         mask_next = 3'b000;
    endcase
  end

  assign grad_val[2] = hx[POS_BITS-1 -: COLOR_BITS];
  assign grad_val[1] = bus.vPos[POS_BITS-1 -: COLOR_BITS];
  assign grad_val[0] = '0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      always_comb begin
        rgb_next[gi] = '0;
        if (bus.videoActive) begin
          if (grad_sel)
            rgb_next[gi] = grad_val[gi];
          else
            rgb_next[gi] = {COLOR_BITS{mask_next[gi]}};
        end
      end

      always_ff @(posedge clk40) begin
        if (reset)
          rgb_reg[gi] <= '0;
        else
          rgb_reg[gi] <= rgb_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk40) begin
    if (reset) begin
      mode_reg        <= MODE_CHECKER;
      scroll_reg      <= '0;
      frame_count_reg <= '0;
      vsync_d_reg     <= ~SYNC_ACT;
      hsync_reg       <= ~SYNC_ACT;
      bar_px_reg      <= '0;
      bar_idx_reg     <= '0;
    end else begin
      hsync_reg   <= bus.hsync_in;
      vsync_d_reg <= bus.vsync_in;

      if (frame_start) begin
        mode_reg        <= bus.mode;
        frame_count_reg <= frame_count_reg + 8'd1;
        if (bus.scroll_en)
          scroll_reg <= scroll_reg + POS_BITS'(SCROLL_STEP);
      end

      // Bar counter runs in every mode so switching into bars mid-line stays aligned.
      if (!bus.videoActive) begin
        bar_px_reg  <= '0;
        bar_idx_reg <= '0;
      end else if (bar_px_reg == BAR_PX_BITS'(BAR_W - 1)) begin
        bar_px_reg <= '0;
        if (bar_idx_reg != 3'd7)
          bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_px_reg <= bar_px_reg + 1'b1;
      end
    end
  end

  assign bus.red        = rgb_reg[2];
  assign bus.green      = rgb_reg[1];
  assign bus.blue       = rgb_reg[0];
  assign bus.hsync      = hsync_reg;
  assign bus.vsync      = vsync_d_reg;
  assign bus.frameCount = frame_count_reg;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: each driven cycle pushes its expected output word,
// which is popped and compared one cycle later.
module tb_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_gen_if #(.COLOR_BITS(4), .POS_BITS(10)) bus ();

  pattern_gen #(
    .COLOR_BITS(4), .POS_BITS(10), .SQUARE_LOG2(4),
    .H_ACTIVE(800), .SCROLL_STEP(1), .SYNC_POL(1)
  ) dut (
    .clk40 (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [21:0] val;   // {red, green, blue, hsync, vsync, frameCount}
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state kept independently of the DUT.
  logic [2:0] m_mode   = 3'd0;
  logic [9:0] m_scroll = 10'd0;
  logic [7:0] m_fc     = 8'd0;
  logic       m_vsd    = 1'b0;
  int         m_cnt    = 0;   // active pixels seen since the last blank cycle

  logic [2:0] req_mode = 3'd0;
  logic       req_se   = 1'b0;

  function automatic logic [11:0] model_rgb(input logic va, input logic [2:0] md,
                                            input logic [9:0] hx, input logic [9:0] v,
                                            input int cnt);
    logic [2:0] m;
    int bar;
    m   = 3'b000;
    bar = cnt / 100;
    if (bar > 7) bar = 7;
    if (!va) return 12'h000;
    case (md)
      3'd0: m = {hx[4], v[4], ~hx[4]};
      3'd1: begin
        case (bar)
          0: m = 3'b111;
          1: m = 3'b110;
          2: m = 3'b011;
          3: m = 3'b010;
          4: m = 3'b101;
          5: m = 3'b100;
          6: m = 3'b001;
          default: m = 3'b000;
        endcase
      end
      3'd2: return {hx[9:6], v[9:6], 4'h0};
      3'd3: m = 3'b111;
      3'd4: m = ((hx[3:0] == 4'd0) || (v[3:0] == 4'd0)) ? 3'b111 : 3'b000;
      default: m = 3'b000;
    endcase
    return {{4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
  endfunction

  task automatic check_one();
    exp_t e;
    logic [21:0] got;
    got = {bus.red, bus.green, bus.blue, bus.hsync, bus.vsync, bus.frameCount};
    n_asserts++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", got);
    end else begin
      e = sb.pop_front();
      assert (got === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic drive(input logic r, input logic va, input int h, input int v,
                       input logic hs, input logic vs, input string tag);
    exp_t e;
    logic [9:0] hx;
    logic [11:0] rgb;
    @(negedge clk);
    rst             = r;
    bus.videoActive = va;
    bus.hPos        = 10'(h);
    bus.vPos        = 10'(v);
    bus.hsync_in    = hs;
    bus.vsync_in    = vs;
    bus.mode        = req_mode;
    bus.scroll_en   = req_se;
    if (r) begin
      m_mode = 3'd0; m_scroll = 10'd0; m_fc = 8'd0; m_vsd = 1'b0; m_cnt = 0;
      e.val = 22'h0;
    end else begin
      hx  = 10'(h) + m_scroll;
      rgb = model_rgb(va, m_mode, hx, 10'(v), m_cnt);
      if (!m_vsd && vs) begin
        m_mode = req_mode;
        m_fc   = m_fc + 8'd1;
        if (req_se) m_scroll = m_scroll + 10'd1;
      end
      m_vsd = vs;
      m_cnt = va ? m_cnt + 1 : 0;
      e.val = {rgb, hs, vs, m_fc};
    end
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  task automatic px(input int h, input int v, input string tag);
    drive(1'b0, 1'b1, h, v, 1'($urandom_range(0, 1)), 1'b0, tag);
  endtask

  task automatic blank(input string tag);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, tag);
  endtask

  // One short frame: vsync leading edge (optionally during active video), then vsync low.
  task automatic pulse(input logic va, input string tag);
    drive(1'b0, va, 0, 0, 1'b0, 1'b1, tag);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    bus.videoActive = 1'b0; bus.hPos = '0; bus.vPos = '0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.mode = 3'd0; bus.scroll_en = 1'b0;

    // Reset held with live timing on the inputs.
    drive(1'b1, 1'b1, 16, 16, 1'b1, 1'b1, "reset0");
    drive(1'b1, 1'b1, 16, 16, 1'b1, 1'b0, "reset1");
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "reset2");

    // Checker before any frame boundary.
    px(16, 16, "checker_16_16");
    px(15, 16, "checker_15_16");
    px(15, 15, "checker_15_15");
    blank("checker_blank");

    // Mode request mid-frame must not change the pattern.
    req_mode = 3'd1;
    px(16, 16, "midframe_hold_a");
    px(40, 3, "midframe_hold_b");
    blank("midframe_blank");
    pulse(1'b0, "bars_frame");

    for (int line = 0; line < 2; line++) begin
      blank("bars_hblank");
      for (int h = 0; h < 800; h++) px(h, 20 + line, $sformatf("bars_l%0d_h%0d", line, h));
    end
    blank("bars_end");

    // Scrolling checker: 16 frames then pixel 0 lands in a red cell.
    req_mode = 3'd0;
    req_se   = 1'b1;
    repeat (16) pulse(1'b0, "scroll_frame");
    px(0, 3, "scroll16_h0");
    px(15, 3, "scroll16_h15");
    // Scroll continues to 1024 frames total and wraps back to 0; frameCount wraps several times.
    repeat (1008) pulse(1'b0, "scroll_wrap_frame");
    px(0, 3, "scroll_wrapped_h0");
    req_se = 1'b0;
    pulse(1'b0, "scroll_off_frame");
    px(0, 3, "scroll_hold_h0");

    // Every mode, with the boundary landing on an active pixel.
    for (int md = 0; md < 8; md++) begin
      req_mode = 3'(md);
      px(33, 5, $sformatf("pre_mode%0d", md));
      pulse(1'b1, $sformatf("boundary_active_mode%0d", md));
      px(32, 5,  $sformatf("mode%0d_32_5", md));
      px(33, 5,  $sformatf("mode%0d_33_5", md));
      px(33, 16, $sformatf("mode%0d_33_16", md));
      for (int k = 0; k < 3; k++)
        px($urandom_range(0, 799), $urandom_range(0, 599), $sformatf("mode%0d_rand%0d", md, k));
      blank($sformatf("mode%0d_blank", md));
      px(700, 599, $sformatf("mode%0d_700_599", md));
    end

    // Reset during active video with gradient selected.
    req_mode = 3'd2;
    req_se   = 1'b1;
    pulse(1'b0, "grad_frame");
    px(640, 512, "grad_before_reset");
    drive(1'b1, 1'b1, 640, 512, 1'b1, 1'b0, "reset_midframe");
    px(16, 16, "after_reset_checker");
    px(640, 512, "after_reset_checker_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
